dmem_resp: RTL

Data-memory responder serving the pipeline's MEM-stage load/store requests. Holds a word-addressed RAM, accepts one request at a time, models a configurable access latency, and raises `stall` so the pipeline freezes until the response is ready. Performs store byte-lane masking and load sign/zero extension, and flags misaligned or malformed requests.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_resp_if.sv | 22 ++
 rtl/dmem_lane.sv | 71 +++++++
 rtl/dmem_resp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared access-width codes, FSM state type and counter helper for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_SB   = 2'b01;
  localparam logic [1:0] WM_SH   = 2'b10;
  localparam logic [1:0] WM_SW   = 2'b11;

  localparam logic [2:0] RM_NONE = 3'b000;
  localparam logic [2:0] RM_LB   = 3'b001;
  localparam logic [2:0] RM_LH   = 3'b010;
  localparam logic [2:0] RM_LW   = 3'b011;
  localparam logic [2:0] RM_LBU  = 3'b100;
  localparam logic [2:0] RM_LHU  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// MEM-stage request / response bundle between the pipeline (master) and the data memory (slave).
interface dmem_resp_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_write_mem;
  logic [2:0]  req_read_mem;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_write_mem, req_read_mem,
    input  stall, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write_mem, req_read_mem,
    output stall, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane datapath: store byte enables / lane-aligned write data, load extract and extend,
// and the misaligned / malformed request check. Purely combinational.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_mem,
  input  logic [2:0]  read_mem,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        half_acc;
  logic        word_acc;

  assign sel_byte = rd_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = rd_word[{addr_lo[1], 4'b0000} +: 16];

  assign half_acc = (write_mem == WM_SH) || (read_mem == RM_LH) || (read_mem == RM_LHU);
  assign word_acc = (write_mem == WM_SW) || (read_mem == RM_LW);

  always_comb begin
    err = 1'b0;
    if ((write_mem != WM_NONE) && (read_mem != RM_NONE)) err = 1'b1;
    if (read_mem[2] && read_mem[1])                      err = 1'b1;
    if (half_acc && addr_lo[0])                          err = 1'b1;
    if (word_acc && (addr_lo != 2'b00))                  err = 1'b1;
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = 32'd0;
    case (write_mem)
      WM_SB: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{wdata[7:0]}};
      end
      WM_SH: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      WM_SW: begin
        byte_en = 4'b1111;
        wr_word = wdata;
      end
      default: ;
    endcase
    if (err) byte_en = 4'b0000;
  end

  always_comb begin
    ld_data = 32'd0;
    case (read_mem)
      RM_LB:   ld_data = {{24{sel_byte[7]}}, sel_byte};
      RM_LH:   ld_data = {{16{sel_half[15]}}, sel_half};
      RM_LW:   ld_data = rd_word;
      RM_LBU:  ld_data = {24'd0, sel_byte};
      RM_LHU:  ld_data = {16'd0, sel_half};
      default: ld_data = 32'd0;
    endcase
    if (err) ld_data = 32'd0;
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM behind a one-request-at-a-time FSM with LATENCY wait cycles.
// Define DMEM_RESP_STATS_EN to add saturating load/store/error counters.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_resp_if.slave bus
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          wm_q, wm_d;
  logic [2:0]          rm_q, rm_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                accept;
  logic                stall;
  logic                ram_we;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         rd_word;
  logic [3:0]          byte_en;
  logic [31:0]         wr_word;
  logic [31:0]         ld_data;
  logic                lane_err;
  logic                unused_addr_hi;

  logic [31:0] mem [2**ADDR_W];

  assign accept         = bus.req_valid &&
                          ((bus.req_write_mem != WM_NONE) || (bus.req_read_mem != RM_NONE));
  assign word_idx       = addr_q[ADDR_W+1:2];
  assign rd_word        = mem[word_idx];
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  dmem_lane u_lane (
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .write_mem (wm_q),
    .read_mem  (rm_q),
    .rd_word   (rd_word),
    .byte_en   (byte_en),
    .wr_word   (wr_word),
    .ld_data   (ld_data),
    .err       (lane_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wm_d    = wm_q;
    rm_d    = rm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = accept;
        if (accept) begin
          addr_d  = bus.req_addr[ADDR_W+1:0];
          wdata_d = bus.req_wdata;
          wm_d    = bus.req_write_mem;
          rm_d    = bus.req_read_mem;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The lane already zeroes enables and load data for errored requests.
          rdata_d = ld_data;
          err_d   = lane_err;
          ram_we  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wm_q    <= wm_d;
    rm_q    <= rm_d;
  end

  // Reset forces IDLE, so a store caught mid-wait never reaches this write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

  assign bus.stall     = stall;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

`ifdef DMEM_RESP_STATS_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == RESP) begin
      if (err_q)                 errs_d   = sat_inc(errs_q);
      else if (wm_q != WM_NONE)  stores_d = sat_inc(stores_q);
      else if (rm_q != RM_NONE)  loads_d  = sat_inc(loads_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      errs_q   <= 32'd0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule
